mem_server: RTL and testbench
=============================

MEM_SERVER -- requirements
Module: mem_server

Interface
REQ-001 Parameter p_opaq_bits, default 8: width of the opaque tag returned unchanged with each response.
REQ-002 Parameter p_num_words, default 256: memory depth in 32-bit words; SHALL be a power of two.
REQ-003 Parameter p_latency, default 1: request-to-response latency in cycles; legal range 1..4.
REQ-004 Parameter p_resp_depth, default 2: maximum number of outstanding transactions; SHALL be at least 1.
REQ-005 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-low.
REQ-007 Port req_val, input, 1: the client presents a request.
REQ-008 Port req_rdy, output, 1: the server accepts a request this cycle.
REQ-009 Port req_op, input, 1: 0 = read, 1 = write.
REQ-010 Port req_addr, input, 32: byte address.
REQ-011 Port req_data, input, 32: write data.
REQ-012 Port req_strb, input, 4: byte write enables for a write; ignored on a read.
REQ-013 Port req_opaque, input, p_opaq_bits: client tag.
REQ-014 Port resp_val, output, 1: the server presents a response.
REQ-015 Port resp_rdy, input, 1: the client accepts the response.
REQ-016 Port resp_op, output, 1: echoes req_op.
REQ-017 Port resp_addr, output, 32: echoes req_addr.
REQ-018 Port resp_data, output, 32: read data; 0 for a write.
REQ-019 Port resp_opaque, output, p_opaq_bits: echoes req_opaque.

Function
REQ-020 A request fires when req_val and req_rdy are both high in the same cycle; a response fires when resp_val and resp_rdy are both high in the same cycle.
REQ-021 Word index SHALL be req_addr[$clog2(p_num_words)+1:2]; upper address bits and req_addr[1:0] are ignored, so addresses wrap modulo 4*p_num_words.
REQ-022 A write SHALL update, on its fire edge, each byte lane b for which req_strb[b]=1; other lanes are unchanged.
REQ-023 A read SHALL sample the memory word on its fire edge, so a read fired in the cycle after a write to the same word returns the written data.
REQ-024 Responses SHALL be returned strictly in request order.
REQ-025 A response SHALL be eligible to assert resp_val exactly p_latency cycles after its request fired; a request firing in cycle t has its earliest response in cycle t+p_latency.
REQ-026 Eligible responses not yet accepted SHALL be held in a FIFO; while resp_val=1 and resp_rdy=0, all resp_* outputs stay stable.
REQ-027 An outstanding counter SHALL increment on request fire, decrement on response fire, and stay unchanged when both occur in the same cycle.
REQ-028 req_rdy SHALL equal (count < p_resp_depth), depend only on registered state, and not depend combinationally on req_val or resp_rdy.
REQ-029 The counter bound guarantees the in-flight pipeline and FIFO never overflow; with p_resp_depth >= p_latency+1 and resp_rdy held high, one request SHALL be accepted every cycle.
REQ-030 With resp_rdy low, at most p_resp_depth requests are accepted, after which req_rdy=0 until a response fires; req_rdy returns to 1 in the cycle after that response fire.
REQ-031 resp_val SHALL be 0 when the FIFO is empty; the payload outputs are don't-care when resp_val=0.

Reset
REQ-032 While rst=0: req_rdy=0, resp_val=0, counter=0, and all in-flight pipeline stages and FIFO entries are invalidated.
REQ-033 Transactions outstanding when reset asserts are discarded and never produce a response.
REQ-034 Memory contents SHALL NOT be reset; writes that fired before reset asserted persist.
REQ-035 In the first cycle after rst deasserts, req_rdy=1 and resp_val=0.

Verification
REQ-036 Write 0xDEADBEEF to 0x10 (strb=0xF, opaque=0x3), then read 0x10 (opaque=0x4); resp_rdy=1 -> responses {op=1, data=0, opaque=0x3} then {op=0, data=0xDEADBEEF, opaque=0x4}, each p_latency cycles after its request.
REQ-037 Over word 0x10 = 0xDEADBEEF, write 0x000000AA with strb=0x1, then read -> read data 0xDEADBEAA.
REQ-038 p_latency=1, p_resp_depth=2, resp_rdy=1, 8 back-to-back reads -> req_rdy stays 1 throughout; 8 responses in consecutive cycles, in order.
REQ-039 resp_rdy=0, 4 reads offered -> exactly 2 accepted, then req_rdy=0; with resp_val high, payload stable; raise resp_rdy -> req_rdy=1 in the cycle after the first response fires.
REQ-040 p_num_words=256: write 0x55 at 0x400, read 0x000 -> returns 0x55 (address wrap).
REQ-041 Assert rst with 2 transactions outstanding, then release -> no responses appear, req_rdy=1 in the first cycle after release, and previously written data is still readable.

Source files
------------

// File: rtl/mem_server.sv
// mem_server: word-addressed memory serving in-order read/write requests with opaque-tagged responses.
// Latency: a response becomes eligible p_latency cycles after its request fires, then waits in a response FIFO.
// Backpressure: req_rdy drops while p_resp_depth transactions are outstanding; resp_rdy low holds the FIFO head stable.
module mem_server #(
  parameter int p_opaq_bits  = 8,
  parameter int p_num_words  = 256,
  parameter int p_latency    = 1,
  parameter int p_resp_depth = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic                   req_op,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_data,
  input  logic [3:0]             req_strb,
  input  logic [p_opaq_bits-1:0] req_opaque,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic                   resp_op,
  output logic [31:0]            resp_addr,
  output logic [31:0]            resp_data,
  output logic [p_opaq_bits-1:0] resp_opaque
);
  localparam int AW = $clog2(p_num_words);
  localparam int PW = (p_resp_depth > 1) ? $clog2(p_resp_depth) : 1;
  localparam int CW = $clog2(p_resp_depth + 1);

  typedef struct packed {
    logic                   op;
    logic [31:0]            addr;
    logic [31:0]            data;
    logic [p_opaq_bits-1:0] opaque;
  } ent_t;

  logic [31:0]   r_mem [p_num_words];
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_rdy;
  logic          w_req_fire;
  logic          w_resp_fire;
  logic [AW-1:0] w_idx;
  logic          w_unused_addr;
  ent_t          w_req_ent;
  logic          w_fin_vld;
  ent_t          w_fin_dat;
  ent_t          r_fifo [p_resp_depth];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_fcnt;
  logic [CW-1:0] w_fcnt_nxt;

  assign w_req_fire    = req_val & r_rdy;
  assign w_resp_fire   = resp_val & resp_rdy;
  assign w_idx         = req_addr[AW+1:2];
  // Upper address bits and the byte offset do not select anything; addresses wrap.
  assign w_unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

  // Ready is registered so it never depends combinationally on req_val or resp_rdy.
  assign req_rdy = r_rdy;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] i_p);
    if (i_p == PW'(p_resp_depth - 1)) return '0;
    return i_p + 1'b1;
  endfunction

  // Build the response entry; reads sample the memory word on the fire edge.
  always_comb begin
    w_req_ent        = '0;
    w_req_ent.op     = req_op;
    w_req_ent.addr   = req_addr;
    w_req_ent.opaque = req_opaque;
    w_req_ent.data   = req_op ? 32'h0 : r_mem[w_idx];
  end

  // Byte-lane writes on the fire edge; memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_req_fire && req_op) begin
      for (int b = 0; b < 4; b++) begin
        if (req_strb[b]) r_mem[w_idx][8*b +: 8] <= req_data[8*b +: 8];
      end
    end
  end

  // Outstanding-transaction count: +1 on request fire, -1 on response fire.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_req_fire && !w_resp_fire)      w_cnt_nxt = r_cnt + 1'b1;
    else if (!w_req_fire && w_resp_fire) w_cnt_nxt = r_cnt - 1'b1;
  end

  // Counter and ready register; ready stays low throughout reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_rdy <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_rdy <= (w_cnt_nxt < CW'(p_resp_depth));
    end
  end

  generate
    if (p_latency == 1) begin : g_direct
      assign w_fin_vld = w_req_fire;
      assign w_fin_dat = w_req_ent;
    end else begin : g_pipe
      logic [p_latency-2:0] r_vld;
      ent_t                 r_dat [p_latency-1];

      // Delay-line valid bits, flushed on reset so in-flight work is discarded.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_vld <= '0;
        end else begin
          r_vld[0] <= w_req_fire;
          for (int s = 1; s < p_latency - 1; s++) r_vld[s] <= r_vld[s-1];
        end
      end

      // Delay-line payload; qualified by r_vld so it needs no reset.
      always_ff @(posedge clk) begin
        r_dat[0] <= w_req_ent;
        for (int s = 1; s < p_latency - 1; s++) r_dat[s] <= r_dat[s-1];
      end

      assign w_fin_vld = r_vld[p_latency-2];
      assign w_fin_dat = r_dat[p_latency-2];
    end
  endgenerate

  // FIFO occupancy; the outstanding bound means a push never meets a full FIFO.
  always_comb begin
    w_fcnt_nxt = r_fcnt;
    if (w_fin_vld && !w_resp_fire)      w_fcnt_nxt = r_fcnt + 1'b1;
    else if (!w_fin_vld && w_resp_fire) w_fcnt_nxt = r_fcnt - 1'b1;
  end

  // FIFO pointers and count; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fcnt   <= '0;
    end else begin
      if (w_fin_vld)   r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_resp_fire) r_rd_ptr <= f_inc(r_rd_ptr);
      r_fcnt <= w_fcnt_nxt;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (w_fin_vld) r_fifo[r_wr_ptr] <= w_fin_dat;
  end

  assign resp_val    = (r_fcnt != '0);
  assign resp_op     = r_fifo[r_rd_ptr].op;
  assign resp_addr   = r_fifo[r_rd_ptr].addr;
  assign resp_data   = r_fifo[r_rd_ptr].data;
  assign resp_opaque = r_fifo[r_rd_ptr].opaque;
endmodule

// File: tb/tb_mem_server.sv
// tb_mem_server: randomized and directed stimulus checked every cycle against a transaction-level model.
// Latency: model predicts resp_val from each transaction's due cycle; payload compared on every valid cycle.
// Backpressure: resp_rdy driven low/high/random; req_rdy predicted from the outstanding-transaction count.
module tb_mem_server;
  localparam int OB    = 8;
  localparam int WORDS = 256;
  localparam int LAT   = 1;
  localparam int DEPTH = 2;

  logic          clk;
  logic          rst;
  logic          req_val;
  logic          req_rdy;
  logic          req_op;
  logic [31:0]   req_addr;
  logic [31:0]   req_data;
  logic [3:0]    req_strb;
  logic [OB-1:0] req_opaque;
  logic          resp_val;
  logic          resp_rdy;
  logic          resp_op;
  logic [31:0]   resp_addr;
  logic [31:0]   resp_data;
  logic [OB-1:0] resp_opaque;

  mem_server #(
    .p_opaq_bits (OB),
    .p_num_words (WORDS),
    .p_latency   (LAT),
    .p_resp_depth(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_strb   (req_strb),
    .req_opaque (req_opaque),
    .resp_val   (resp_val),
    .resp_rdy   (resp_rdy),
    .resp_op    (resp_op),
    .resp_addr  (resp_addr),
    .resp_data  (resp_data),
    .resp_opaque(resp_opaque)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          op;
    bit [31:0]   addr;
    bit [31:0]   data;
    bit [OB-1:0] opq;
    int          due;
  } exp_t;

  exp_t        q[$];
  bit   [31:0] m_mem [WORDS];
  bit          m_live;
  int          cyc;
  int          n_cmp;
  int          n_bad;
  int          n_acc;
  bit   [31:0] last_rd;
  bit          rnd_mode;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Transaction-level model: outstanding queue with due cycles plus a word array.
  always @(negedge clk) begin
    bit   exp_rdy;
    bit   exp_val;
    exp_t e;
    int   w;
    if (!rst) begin
      m_live = 1'b0;
      q.delete();
    end
    exp_rdy = m_live && (q.size() < DEPTH);
    exp_val = (q.size() > 0) && (q[0].due <= cyc);
    chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
    chk("resp_val", 64'(resp_val), 64'(exp_val));
    if (resp_val && exp_val) begin
      chk("resp_op", 64'(resp_op), 64'(q[0].op));
      chk("resp_addr", 64'(resp_addr), 64'(q[0].addr));
      chk("resp_data", 64'(resp_data), 64'(q[0].data));
      chk("resp_opaque", 64'(resp_opaque), 64'(q[0].opq));
    end
    if (resp_val && resp_rdy && q.size() > 0) begin
      if (!resp_op) last_rd = resp_data;
      void'(q.pop_front());
    end
    if (req_val && req_rdy) begin
      n_acc++;
      w     = int'((req_addr / 4) % WORDS);
      e.op  = req_op;
      e.addr = req_addr;
      e.opq = req_opaque;
      e.due = cyc + LAT;
      e.data = req_op ? 32'h0 : m_mem[w];
      if (req_op) begin
        for (int b = 0; b < 4; b++)
          if (req_strb[b]) m_mem[w][8*b +: 8] = req_data[8*b +: 8];
      end
      q.push_back(e);
    end
    m_live = rst;
  end

  task automatic rnd_rdy();
    if (rnd_mode) resp_rdy = ($urandom_range(0, 3) != 0);
  endtask

  // Offer one request until it fires; returns aligned to posedge+1.
  task automatic send(input bit op, input bit [31:0] addr, input bit [31:0] data,
                      input bit [3:0] strb, input bit [OB-1:0] opq);
    bit fired;
    int n;
    req_val = 1'b1; req_op = op; req_addr = addr; req_data = data;
    req_strb = strb; req_opaque = opq;
    n = 0;
    do begin
      rnd_rdy();
      @(negedge clk);
      fired = req_rdy;
      @(posedge clk);
      #1;
      n++;
    end while (!fired && n < 100);
    if (!fired) chk("req_timeout", 64'(fired), 64'd1);
    req_val = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      rnd_rdy();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    resp_rdy = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int t0;
    n_cmp = 0; n_bad = 0; n_acc = 0; cyc = 0; m_live = 1'b0; rnd_mode = 1'b0;
    rst = 1'b0; req_val = 1'b0; req_op = 1'b0; req_addr = '0; req_data = '0;
    req_strb = '0; req_opaque = '0; resp_rdy = 1'b1; last_rd = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    // Fill every word so all later reads have a known model value.
    for (int w = 0; w < WORDS; w++) send(1'b1, 32'(w * 4), $urandom, 4'hF, OB'(w));
    drain();

    // Full write then read back.
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 8'h03);
    send(1'b0, 32'h10, 32'h0, 4'h0, 8'h04);
    drain();
    chk("rd_deadbeef", 64'(last_rd), 64'hDEADBEEF);

    // Single-lane partial write.
    send(1'b1, 32'h10, 32'h000000AA, 4'h1, 8'h05);
    send(1'b0, 32'h10, 32'h0, 4'h0, 8'h06);
    drain();
    chk("rd_strb", 64'(last_rd), 64'hDEADBEAA);

    // Address wrap modulo 4*p_num_words.
    send(1'b1, 32'h400, 32'h55, 4'hF, 8'h07);
    send(1'b0, 32'h000, 32'h0, 4'h0, 8'h08);
    drain();
    chk("rd_wrap", 64'(last_rd), 64'h55);

    // Back-to-back reads with resp_rdy high: one accepted per cycle.
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(1'b0, 32'(i * 4), 32'h0, 4'h0, OB'(8'h20 + i));
    chk("b2b_cycles", 64'(cyc - t0), 64'd8);
    drain();

    // Response stall: only DEPTH requests get in.
    resp_rdy = 1'b0;
    n_acc = 0;
    req_val = 1'b1; req_op = 1'b0; req_addr = 32'h10; req_opaque = 8'h09;
    repeat (6) begin @(posedge clk); #1; end
    req_val = 1'b0;
    chk("held_accepts", 64'(n_acc), 64'(DEPTH));
    chk("held_rdy", 64'(req_rdy), 64'd0);
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    chk("rdy_reopen", 64'(req_rdy), 64'd1);
    drain();

    // Reset with transactions in flight.
    send(1'b1, 32'h20, 32'h12345678, 4'hF, 8'h0A);
    drain();
    resp_rdy = 1'b0;
    send(1'b0, 32'h20, 32'h0, 4'h0, 8'h0B);
    send(1'b0, 32'h24, 32'h0, 4'h0, 8'h0C);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_val", 64'(resp_val), 64'd0);
    rst = 1'b1;
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_rdy", 64'(req_rdy), 64'd1);
    chk("rst_release_val", 64'(resp_val), 64'd0);
    idle(5);
    last_rd = '0;
    send(1'b0, 32'h20, 32'h0, 4'h0, 8'h0D);
    drain();
    chk("rd_after_rst", 64'(last_rd), 64'h12345678);

    // Randomized mix with random response backpressure.
    rnd_mode = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      else send(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)), OB'($urandom));
    end
    rnd_mode = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
